// File: rtl/norm_pkg.sv
// norm_pkg: shared state type and default widths for the
// FP normalization controller.
package norm_pkg;

    parameter int MANT_W   = 32;
    parameter int EXP_W    = 8;
    parameter int NORM_BIT = 23;
    parameter int EXP_MAX  = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/norm_shift_unit.sv
// norm_shift_unit: working mantissa/exponent/count registers
// stepped one bit per cycle under control of norm_arbiter.
module norm_shift_unit #(
    parameter int MANT_W   = 32,
    parameter int EXP_W    = 8,
    parameter int NORM_BIT = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [MANT_W-1:0] i_mant,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic              i_shl,
    input  logic              i_shr,
    input  logic              i_sat,
    output logic [MANT_W-1:0] o_mant,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant_nxt,
    output logic [EXP_W-1:0]  o_exp_nxt,
    output logic [5:0]        o_count_nxt,
    output logic              o_is_zero,
    output logic              o_is_high,
    output logic              o_is_aligned
);
    import norm_pkg::*;

    logic [MANT_W-1:0] r_mant;
    logic [EXP_W-1:0]  r_exp;
    logic [5:0]        r_count;
    logic [MANT_W-1:0] w_mant_nxt;
    logic [EXP_W-1:0]  w_exp_nxt;
    logic [5:0]        w_count_nxt;

    always_comb begin
        w_mant_nxt  = r_mant;
        w_exp_nxt   = r_exp;
        w_count_nxt = r_count;
        if (i_load) begin
            w_mant_nxt  = i_mant;
            w_exp_nxt   = i_exp;
            w_count_nxt = '0;
        end else if (i_shl) begin
            w_mant_nxt  = r_mant << 1;
            w_exp_nxt   = r_exp - EXP_W'(1);
            w_count_nxt = r_count + 6'd1;
        end else if (i_shr) begin
            // Saturating step pins the exponent at its ceiling.
            w_mant_nxt  = r_mant >> 1;
            w_exp_nxt   = i_sat ? '1 : r_exp + EXP_W'(1);
            w_count_nxt = r_count - 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mant  <= '0;
            r_exp   <= '0;
            r_count <= '0;
        end else begin
            r_mant  <= w_mant_nxt;
            r_exp   <= w_exp_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_mant       = r_mant;
    assign o_exp        = r_exp;
    assign o_mant_nxt   = w_mant_nxt;
    assign o_exp_nxt    = w_exp_nxt;
    assign o_count_nxt  = w_count_nxt;
    assign o_is_zero    = (r_mant == '0);
    assign o_is_high    = |r_mant[MANT_W-1:NORM_BIT+1];
    assign o_is_aligned = r_mant[NORM_BIT];

endmodule

// File: rtl/norm_arbiter.sv
// norm_arbiter: round-robin front end and FSM driving one
// iterative normalizer shared by two requesters.
module norm_arbiter #(
    parameter int MANT_W   = 32,
    parameter int EXP_W    = 8,
    parameter int NORM_BIT = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [MANT_W-1:0] mant0,
    input  logic [MANT_W-1:0] mant1,
    input  logic [EXP_W-1:0]  exp0,
    input  logic [EXP_W-1:0]  exp1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              done,
    output logic              out_id,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [5:0]        out_shift,
    output logic              out_zero,
    output logic              out_unf,
    output logic              out_ovf
);
    import norm_pkg::*;

    localparam logic [EXP_W-1:0] EXP_SAT = EXP_W'((1 << EXP_W) - 2);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_gnt;
    logic              r_last_id;
    logic              r_cap_id;
    logic              w_sel;
    logic [MANT_W-1:0] w_cap_mant;
    logic [EXP_W-1:0]  w_cap_exp;

    logic w_load, w_shl, w_shr, w_sat;
    logic w_fin, w_zero, w_unf, w_ovf;

    logic [MANT_W-1:0] w_mant;
    logic [EXP_W-1:0]  w_exp;
    logic [MANT_W-1:0] w_mant_nxt;
    logic [EXP_W-1:0]  w_exp_nxt;
    logic [5:0]        w_count_nxt;
    logic              w_is_zero, w_is_high, w_is_aligned;

    logic [MANT_W-1:0] r_out_mant;
    logic [EXP_W-1:0]  r_out_exp;
    logic [5:0]        r_out_shift;
    logic              r_out_id;
    logic              r_out_zero, r_out_unf, r_out_ovf;

    // On a tie, the requester not served last time wins.
    assign w_sel      = (req == 2'b11) ? ~r_last_id : req[1];
    assign w_cap_mant = w_sel ? mant1 : mant0;
    assign w_cap_exp  = w_sel ? exp1 : exp0;

    norm_shift_unit #(
        .MANT_W   (MANT_W),
        .EXP_W    (EXP_W),
        .NORM_BIT (NORM_BIT)
    ) u_shift (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_mant       (w_cap_mant),
        .i_exp        (w_cap_exp),
        .i_shl        (w_shl),
        .i_shr        (w_shr),
        .i_sat        (w_sat),
        .o_mant       (w_mant),
        .o_exp        (w_exp),
        .o_mant_nxt   (w_mant_nxt),
        .o_exp_nxt    (w_exp_nxt),
        .o_count_nxt  (w_count_nxt),
        .o_is_zero    (w_is_zero),
        .o_is_high    (w_is_high),
        .o_is_aligned (w_is_aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shl       = 1'b0;
        w_shr       = 1'b0;
        w_sat       = 1'b0;
        w_fin       = 1'b0;
        w_zero      = 1'b0;
        w_unf       = 1'b0;
        w_ovf       = 1'b0;
        case (r_state)
            IDLE: begin
                if (req != 2'b00) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_is_zero) begin
                    w_fin  = 1'b1;
                    w_zero = 1'b1;
                end else if (w_is_high) begin
                    w_shr = 1'b1;
                    if (w_exp == EXP_SAT) begin
                        w_sat = 1'b1;
                        w_ovf = 1'b1;
                        w_fin = 1'b1;
                    end
                end else if (w_is_aligned) begin
                    w_fin = 1'b1;
                end else if (w_exp <= EXP_W'(1)) begin
                    w_fin = 1'b1;
                    w_unf = 1'b1;
                end else begin
                    w_shl = 1'b1;
                end
                if (w_fin) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt       <= 2'b00;
            r_last_id   <= 1'b1;
            r_cap_id    <= 1'b0;
            r_out_mant  <= '0;
            r_out_exp   <= '0;
            r_out_shift <= '0;
            r_out_id    <= 1'b0;
            r_out_zero  <= 1'b0;
            r_out_unf   <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_gnt <= 2'b00;
            if (w_load) begin
                r_gnt      <= w_sel ? 2'b10 : 2'b01;
                r_last_id  <= w_sel;
                r_cap_id   <= w_sel;
                r_out_zero <= 1'b0;
                r_out_unf  <= 1'b0;
                r_out_ovf  <= 1'b0;
            end
            // Results include any shift taken on the finishing edge.
            if (w_fin) begin
                r_out_mant  <= w_mant_nxt;
                r_out_exp   <= w_exp_nxt;
                r_out_shift <= w_count_nxt;
                r_out_id    <= r_cap_id;
                r_out_zero  <= w_zero;
                r_out_unf   <= w_unf;
                r_out_ovf   <= w_ovf;
            end
        end
    end

    assign gnt       = r_gnt;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign out_id    = r_out_id;
    assign out_mant  = r_out_mant;
    assign out_exp   = r_out_exp;
    assign out_shift = r_out_shift;
    assign out_zero  = r_out_zero;
    assign out_unf   = r_out_unf;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_norm_arbiter.sv
// tb_norm_arbiter: directed vectors with hand-computed results
// for the shared normalization controller.
module tb_norm_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] mant0, mant1;
    logic [7:0]  exp0, exp1;
    logic [1:0]  gnt;
    logic        busy, done, out_id;
    logic [31:0] out_mant;
    logic [7:0]  out_exp;
    logic [5:0]  out_shift;
    logic        out_zero, out_unf, out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    norm_arbiter #(
        .MANT_W   (32),
        .EXP_W    (8),
        .NORM_BIT (23)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mant0     (mant0),
        .mant1     (mant1),
        .exp0      (exp0),
        .exp1      (exp1),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .out_id    (out_id),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_shift (out_shift),
        .out_zero  (out_zero),
        .out_unf   (out_unf),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive a single request and confirm the capture grant.
    task automatic start_op(input logic id,
                            input logic [31:0] m,
                            input logic [7:0] e);
        @(negedge clk);
        if (id) begin
            mant1 = m; exp1 = e; req = 2'b10;
        end else begin
            mant0 = m; exp0 = e; req = 2'b01;
        end
        @(posedge clk); #1;
        check("gnt", {30'd0, gnt}, id ? 32'd2 : 32'd1);
        check("busy", {31'd0, busy}, 32'd1);
        req = 2'b00;
    endtask

    task automatic finish_op(input int lat_w,
                             input logic [31:0] m_w,
                             input logic [7:0] e_w,
                             input logic [5:0] s_w,
                             input logic id_w,
                             input logic [2:0] fl_w);
        int lat;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) check("gnt_pulse", {30'd0, gnt}, 32'd0);
        end
        check("latency", lat, lat_w);
        check("out_mant", out_mant, m_w);
        check("out_exp", {24'd0, out_exp}, {24'd0, e_w});
        check("out_shift", {26'd0, out_shift}, {26'd0, s_w});
        check("out_id", {31'd0, out_id}, {31'd0, id_w});
        check("flags", {29'd0, out_zero, out_unf, out_ovf},
              {29'd0, fl_w});
        @(posedge clk); #1;
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_end", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_mant"}, out_mant, 32'd0);
        check({tag, "_exp"}, {24'd0, out_exp}, 32'd0);
        check({tag, "_shift"}, {26'd0, out_shift}, 32'd0);
        check({tag, "_id"}, {31'd0, out_id}, 32'd0);
        check({tag, "_flags"}, {29'd0, out_zero, out_unf, out_ovf}, 32'd0);
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        req   = 2'b00;
        mant0 = '0; mant1 = '0;
        exp0  = '0; exp1  = '0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        // 23 left shifts from bit 0
        start_op(1'b0, 32'h0000_0001, 8'd100);
        finish_op(24, 32'h0080_0000, 8'd77, 6'd23, 1'b0, 3'b000);

        // 8 right shifts from bit 31
        start_op(1'b1, 32'h8000_0000, 8'd10);
        finish_op(9, 32'h0080_0000, 8'd18, 6'h38, 1'b1, 3'b000);

        // zero operand
        start_op(1'b0, 32'h0000_0000, 8'd50);
        finish_op(1, 32'h0000_0000, 8'd50, 6'd0, 1'b0, 3'b100);

        // exponent floor
        start_op(1'b0, 32'h0000_0100, 8'd3);
        finish_op(3, 32'h0000_0400, 8'd1, 6'd2, 1'b0, 3'b010);

        // exponent saturation
        start_op(1'b0, 32'h0200_0000, 8'd254);
        finish_op(1, 32'h0100_0000, 8'd255, 6'h3F, 1'b0, 3'b001);

        // reset in the middle of a long operation, request held
        @(negedge clk);
        mant0 = 32'h0000_0001; exp0 = 8'd100; req = 2'b01;
        @(posedge clk); #1;
        check("rst_cap_gnt", {30'd0, gnt}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("rst_pre_done", {31'd0, done}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_cleared("abort");
        repeat (2) @(negedge clk);
        check("abort_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reserve_gnt", {30'd0, gnt}, 32'd1);
        req = 2'b00;
        finish_op(24, 32'h0080_0000, 8'd77, 6'd23, 1'b0, 3'b000);

        // fresh reset, then both requesters held with aligned operands
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        mant0 = 32'h0080_0000; exp0 = 8'd20;
        mant1 = 32'h00C0_0000; exp1 = 8'd40;
        req   = 2'b11;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = 0;
            do begin
                @(posedge clk); #1;
                w++;
            end while (gnt == 2'b00 && w < 20);
            check("alt_gnt", {30'd0, gnt}, (i % 2) ? 32'd2 : 32'd1);
            w = 0;
            do begin
                @(posedge clk); #1;
                w++;
            end while (!done && w < 50);
            check("alt_id", {31'd0, out_id}, (i % 2) ? 32'd1 : 32'd0);
            check("alt_exp", {24'd0, out_exp},
                  (i % 2) ? 32'd40 : 32'd20);
        end
        @(negedge clk);
        req = 2'b00;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/norm_arbiter.md
# norm_arbiter

Shared normalization controller for the FP datapath. Accepts unnormalized mantissa/exponent pairs from two requesters (adder and multiplier back-ends), arbitrates round-robin, and drives one iterative one-bit-per-cycle shifter that aligns the leading one to bit NORM_BIT while adjusting the exponent. Returns the normalized result, shift count and exception flags with a one-cycle done pulse tagged by requester ID.

## Interface
Parameters:
- MANT_W, 32, mantissa working width
- EXP_W, 8, biased exponent width
- NORM_BIT, 23, target bit position of the leading one

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-requester request; held high until matching gnt bit seen
- mant0, mant1  in  MANT_W  requester operands, valid while req[i]
- exp0, exp1  in  EXP_W  requester exponents, valid while req[i]
- gnt  out  2  one-hot, one-cycle grant: operand captured
- busy  out  1  high from capture until the done cycle inclusive
- done  out  1  one-cycle result-valid pulse
- out_id  out  1  requester index of current result
- out_mant  out  MANT_W  normalized mantissa
- out_exp  out  EXP_W  adjusted exponent
- out_shift  out  6  signed two's-complement shift count: +left, −right
- out_zero, out_unf, out_ovf  out  1 each  zero operand / exponent floor hit / exponent saturated

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: at an edge with req≠0, select requester, capture mant/exp into working regs, clear count, go SHIFT. gnt[sel] high the following cycle only.
- Arbitration: single request wins. Both: grant the index ≠ last_id; last_id updated on each grant; resets to 1 (requester 0 wins first tie).
- SHIFT, evaluated each edge in priority order:
  - mant==0 → out_zero=1, mant/exp unchanged, go DONE.
  - mant[MANT_W-1:NORM_BIT+1]≠0 → if exp==2^EXP_W−2: mant>>1, exp=2^EXP_W−1, out_ovf=1, go DONE; else mant>>1, exp+1, count−1, stay.
  - mant[NORM_BIT]==1 → go DONE.
  - exp≤1 → out_unf=1, no shift, go DONE.
  - else mant<<1, exp−1, count+1, stay.
- DONE: done=1 one cycle; next edge go IDLE. No capture in DONE.
- out_* registers update only on the SHIFT→DONE edge and hold until the next SHIFT→DONE edge; flags cleared at capture.
- Shift width: logical shifts, zero fill; bits shifted out right are discarded (no rounding).

## Timing
- Reset (async, immediate): state IDLE, gnt=0, busy=0, done=0, out_id=0, out_mant=0, out_exp=0, out_shift=0, all flags 0, last_id=1.
- Capture at edge k; n shifts; done high in cycle after edge k+n+1 (latency n+1). Zero operand: n=0.
- Max n: 23 left (bit0→bit23), 8 right (bit31→bit23) at defaults.
- busy=1 from cycle after capture through done cycle; earliest next capture at the edge ending the done cycle... i.e. IDLE is entered after done; capture on the following edge. Throughput one operation per n+3 cycles.
- A req arriving during SHIFT/DONE waits; it is not lost and no gnt issues until IDLE.
- rst_n low mid-SHIFT: operation aborted, no done, no gnt; after release, a still-held req is served normally.

## Structure
- Package norm_pkg: state enum (IDLE/SHIFT/DONE), MANT_W, EXP_W, NORM_BIT, EXP_MAX=2^EXP_W−1.
- Sub-module norm_shift_unit: working mant/exp/count regs with load, shift-left, shift-right controls and status outputs (is_zero, is_high, is_aligned). norm_arbiter holds the FSM, round-robin pointer, capture mux and output registers.

## Test plan
- req=01, mant0=0x00000001, exp0=100 → gnt=01 one cycle; done 24 cycles after capture; out_mant=0x00800000, out_exp=77, out_shift=+23, out_id=0, flags 0.
- req=10, mant1=0x80000000, exp1=10 → done 9 cycles after capture; out_mant=0x00800000, out_exp=18, out_shift=−8, out_id=1.
- After reset, req=11 held continuously with aligned operands → grants 01,10,01,10 alternating; done tags 0,1,0,1.
- mant0=0, exp0=50 → done 1 cycle after capture; out_zero=1, out_mant=0, out_exp=50, out_shift=0.
- mant0=0x00000100, exp0=3 → out_mant=0x00000400, out_exp=1, out_shift=+2, out_unf=1; mant0=0x02000000, exp0=254 → out_mant=0x01000000, out_exp=255, out_shift=−1, out_ovf=1.
- rst_n pulsed low 5 cycles after capture of 0x00000001 → all outputs 0 immediately, no done; after release, held req re-served with full 24-cycle result.
